// File: rtl/mch_rx.sv
// mch_rx: Manchester receive/decode stage.
//
// Recovers DATA_BITS-wide frames (MSB first) from an oversampled Manchester
// line. A frame is a start bit (encoded 1) followed by the data bits. The
// convention is 0 = high-then-low and 1 = low-then-high, and the idle line is
// low. Bit timing is recovered by restarting the phase counter on every
// accepted mid-bit edge.
//
// Ports:
//   clk       in   system clock (100 MHz)
//   btnl      in   reset, asynchronous, active-high
//   rxsd      in   serial Manchester line, asynchronous to clk
//   rx_data   out  last good frame, held until the next good frame
//   rx_valid  out  one-cycle pulse when rx_data updates
//   rx_err    out  one-cycle pulse on a code violation
//   err_cnt   out  saturating count of rx_err pulses
//   busy      out  high while a frame is being received
`timescale 1ns/1ps
module mch_rx #(
  parameter int BIT_CLKS  = 1000,
  parameter int DATA_BITS = 16,
  parameter int IDLE_BITS = 2
) (
  input  logic                 clk,
  input  logic                 btnl,
  input  logic                 rxsd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_err,
  output logic [7:0]           err_cnt,
  output logic                 busy
);

  localparam int Q        = BIT_CLKS / 4;
  localparam int CNT_W    = $clog2(2 * BIT_CLKS);
  localparam int IDLE_MAX = IDLE_BITS * BIT_CLKS;
  localparam int IDLE_W   = $clog2(IDLE_MAX + 1);
  localparam int IDX_W    = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0]  PH_Q      = CNT_W'(Q);
  localparam logic [CNT_W-1:0]  PH_2Q     = CNT_W'(2 * Q);
  localparam logic [CNT_W-1:0]  PH_3Q     = CNT_W'(3 * Q);
  localparam logic [CNT_W-1:0]  PH_TMO    = CNT_W'(5 * Q + 1);
  localparam logic [IDLE_W-1:0] IDLE_FULL = IDLE_W'(IDLE_MAX);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DATA_BITS - 1);

  typedef enum logic [1:0] {HUNT, DATA, STOP, ERR} state_t;

  state_t                state, state_next;
  logic                  s_meta, s_rx, s_dly;
  logic [CNT_W-1:0]      cnt, cnt_next;
  logic [CNT_W-1:0]      phase;
  logic [IDX_W-1:0]      bit_idx, bit_idx_next;
  logic [IDLE_W-1:0]     idle_cnt, idle_next;
  logic [DATA_BITS-1:0]  shift, shift_next;
  logic                  line_edge, rise, load;

  assign line_edge = s_rx ^ s_dly;
  assign rise      = s_rx & ~s_dly;

  // cnt is cleared in the cycle an edge is accepted, so the number of cycles
  // elapsed since that edge (as seen on s_rx) is cnt + 1. All timing windows
  // are measured in elapsed cycles: a nominal mid-bit edge lands at 4Q.
  assign phase = cnt + 1'b1;

  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    bit_idx_next = bit_idx;
    idle_next    = '0;
    shift_next   = shift;
    load         = 1'b0;

    case (state)
      HUNT: begin
        cnt_next  = '0;
        idle_next = idle_cnt;
        if (s_rx) begin
          idle_next = '0;
          // Rising edge after a full idle period is the start-bit mid-point.
          if (rise && idle_cnt == IDLE_FULL) begin
            state_next   = DATA;
            bit_idx_next = '0;
          end
        end else if (idle_cnt != IDLE_FULL) begin
          idle_next = idle_cnt + 1'b1;
        end
      end

      DATA: begin
        cnt_next = cnt + 1'b1;
        if (phase == PH_TMO) begin
          // Mid-bit window closed without an edge.
          state_next = ERR;
        end else if (line_edge) begin
          if (phase < PH_Q) begin
            state_next = ERR;
          end else if (phase >= PH_3Q) begin
            // Mid-bit edge (upper bound already enforced by the timeout).
            shift_next   = {shift[DATA_BITS-2:0], s_rx};
            cnt_next     = '0;
            bit_idx_next = bit_idx + 1'b1;
            if (bit_idx == LAST_IDX) begin
              state_next = STOP;
            end
          end
          // Edges in [Q, 3Q) are bit-boundary transitions and are ignored.
        end
      end

      STOP: begin
        cnt_next = cnt + 1'b1;
        if (phase == PH_2Q) begin
          load       = 1'b1;
          state_next = HUNT;
        end
      end

      ERR: begin
        state_next = HUNT;
      end

      default: begin
        state_next = HUNT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge btnl) begin
    if (btnl) begin
      s_meta   <= 1'b0;
      s_rx     <= 1'b0;
      s_dly    <= 1'b0;
      state    <= HUNT;
      cnt      <= '0;
      bit_idx  <= '0;
      idle_cnt <= '0;
      shift    <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
      err_cnt  <= '0;
      busy     <= 1'b0;
    end else begin
      s_meta   <= rxsd;
      s_rx     <= s_meta;
      s_dly    <= s_rx;
      state    <= state_next;
      cnt      <= cnt_next;
      bit_idx  <= bit_idx_next;
      idle_cnt <= idle_next;
      shift    <= shift_next;
      rx_valid <= load;
      // Registered alongside the state so rx_err is high exactly while in ERR.
      rx_err   <= (state_next == ERR);
      busy     <= (state_next == DATA);
      if (load) begin
        rx_data <= shift;
      end
      if (state_next == ERR && err_cnt != 8'hFF) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_mch_rx.sv
`timescale 1ns/1ps
module tb_mch_rx;

  localparam int BIT_CLKS = 8;
  localparam int Q        = BIT_CLKS / 4;
  localparam int HB       = 2 * Q;          // nominal half-bit length
  localparam int LAT      = 2 * Q + 1 + 2;  // last mid-bit edge on rxsd -> rx_valid
  localparam int POST     = 6;              // low cycles after each frame before checking

  logic        clk = 1'b0;
  logic        btnl;
  logic        rxsd;
  logic [15:0] rx_data;
  logic        rx_valid;
  logic        rx_err;
  logic [7:0]  err_cnt;
  logic        busy;

  always #5 clk = ~clk;

  mch_rx #(.BIT_CLKS(BIT_CLKS), .DATA_BITS(16), .IDLE_BITS(2)) dut (
    .clk      (clk),
    .btnl     (btnl),
    .rxsd     (rxsd),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_err   (rx_err),
    .err_cnt  (err_cnt),
    .busy     (busy)
  );

  typedef struct {
    logic [15:0] data;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [15:0] data;
    int          gap;
    bit          jit;
    int          viol;
    bit          accept;
    bit          err;
  } vec_t;

  exp_t        sb_q[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          err_pending = 0;
  int          exp_errs = 0;
  logic [15:0] exp_data = 16'h0000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h (cyc %0d)", name, act, req, cyc);
    end
  endtask

  // Per-cycle scoreboard: every rx_valid pops one expected frame, every
  // rx_err consumes one announced error.
  task automatic sample();
    exp_t e;
    if (rx_valid || rx_err) check("valid_err_exclusive", {31'd0, rx_valid & rx_err}, 32'd0);
    if (rx_valid) begin
      $display("[TB] cyc %0d rx_valid data=%04h", cyc, rx_data);
      if (sb_q.size() == 0) begin
        check("unexpected_valid", {31'd0, rx_valid}, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("rx_data", {16'd0, rx_data}, {16'd0, e.data});
        check("valid_latency", cyc, e.cyc);
      end
    end
    if (rx_err) begin
      $display("[TB] cyc %0d rx_err err_cnt=%0d", cyc, err_cnt);
      if (err_pending == 0) check("unexpected_err", {31'd0, rx_err}, 32'd0);
      else err_pending--;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic drive(input logic v, input int n);
    rxsd = v;
    repeat (n) tick();
  endtask

  task automatic send_bit(input logic b, input int h1, input int h2, output int mid);
    drive(~b, h1);
    mid = cyc;
    drive(b, h2);
  endtask

  task automatic send_frame(input logic [15:0] d, input int gap, input bit jit,
                            input int viol, output int last_mid);
    int m;
    int h2;
    drive(1'b0, gap);
    send_bit(1'b1, HB, jit ? HB + 1 : HB, m);
    last_mid = m;
    for (int i = 0; i < 16; i++) begin
      // Alternate short/long second halves: mid-bit spacing 7 or 9 cycles.
      h2 = jit ? ((i % 2 == 0) ? HB - 1 : HB + 1) : HB;
      if (i == viol) begin
        drive(1'b1, 2 * HB);
      end else begin
        send_bit(d[15-i], HB, h2, m);
        last_mid = m;
      end
    end
  endtask

  task automatic expect_err();
    err_pending++;
    if (exp_errs < 255) exp_errs++;
  endtask

  task automatic settle_checks(input string tag);
    drive(1'b0, POST);
    check({tag, "_sb_empty"}, sb_q.size(), 32'd0);
    check({tag, "_err_pending"}, err_pending, 32'd0);
    check({tag, "_rx_data"}, {16'd0, rx_data}, {16'd0, exp_data});
    check({tag, "_err_cnt"}, {24'd0, err_cnt}, exp_errs);
    sb_q.delete();
    err_pending = 0;
  endtask

  vec_t vecs[11];

  initial begin
    int          lm;
    logic [15:0] rd;

    // gap = total low time between the end of the previous frame and the
    // start bit's first half; POST of it is spent in settle_checks.
    vecs[0]  = '{16'hA5C3, 16, 1'b0, -1, 1'b1, 1'b0};
    vecs[1]  = '{16'h0000, 20, 1'b0, -1, 1'b1, 1'b0};
    vecs[2]  = '{16'hFFFF, 16, 1'b0, -1, 1'b1, 1'b0};
    vecs[3]  = '{16'h0000, 20, 1'b0, -1, 1'b1, 1'b0};
    vecs[4]  = '{16'hFFFF, 10, 1'b0, -1, 1'b0, 1'b0};
    vecs[5]  = '{16'h0000, 20, 1'b0, -1, 1'b1, 1'b0};
    vecs[6]  = '{16'h1234, 13, 1'b0, -1, 1'b1, 1'b0};
    vecs[7]  = '{16'h5A5A, 12, 1'b0, -1, 1'b0, 1'b0};
    vecs[8]  = '{16'h1234, 20, 1'b1, -1, 1'b1, 1'b0};
    vecs[9]  = '{16'h00FF, 20, 1'b0,  5, 1'b0, 1'b1};
    vecs[10] = '{16'h5555, 20, 1'b0, -1, 1'b1, 1'b0};

    btnl = 1'b1;
    rxsd = 1'b0;
    @(posedge clk);
    #1;
    tick();
    tick();
    check("reset_rx_data", {16'd0, rx_data}, 32'd0);
    check("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("reset_rx_err", {31'd0, rx_err}, 32'd0);
    check("reset_err_cnt", {24'd0, err_cnt}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    btnl = 1'b0;
    drive(1'b0, POST);

    for (int i = 0; i < 11; i++) begin
      if (vecs[i].err) expect_err();
      send_frame(vecs[i].data, vecs[i].gap - POST, vecs[i].jit, vecs[i].viol, lm);
      if (vecs[i].accept) begin
        sb_q.push_back('{vecs[i].data, lm + LAT});
        exp_data = vecs[i].data;
      end
      settle_checks($sformatf("vec%0d", i));
    end

    // Glitch one cycle after a falling mid-bit edge, repeated to saturate err_cnt.
    for (int g = 0; g < 300; g++) begin
      expect_err();
      drive(1'b0, 20);
      drive(1'b0, HB);
      drive(1'b1, 2 * HB);
      drive(1'b0, 1);
      drive(1'b1, 1);
      drive(1'b0, 3);
      if (g % 50 == 0) check($sformatf("glitch%0d_err_cnt", g), {24'd0, err_cnt}, exp_errs);
    end
    settle_checks("glitch_sat");
    check("err_cnt_saturated", {24'd0, err_cnt}, 32'd255);

    // Asynchronous reset during bit 8 of a frame.
    rd = 16'h9AC3;
    drive(1'b0, 20);
    send_bit(1'b1, HB, HB, lm);
    for (int i = 0; i < 8; i++) send_bit(rd[15-i], HB, HB, lm);
    rxsd = ~rd[7];
    tick();
    tick();
    check("busy_mid_frame", {31'd0, busy}, 32'd1);
    #1 btnl = 1'b1;
    #1;
    check("async_rx_data", {16'd0, rx_data}, 32'd0);
    check("async_err_cnt", {24'd0, err_cnt}, 32'd0);
    check("async_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("async_rx_err", {31'd0, rx_err}, 32'd0);
    check("async_busy", {31'd0, busy}, 32'd0);
    tick();
    tick();
    btnl = 1'b0;
    exp_data = 16'h0000;
    exp_errs = 0;
    drive(rd[7], HB);
    for (int i = 9; i < 16; i++) send_bit(rd[15-i], HB, HB, lm);
    settle_checks("post_reset");

    send_frame(16'hBEEF, 20 - POST, 1'b0, -1, lm);
    sb_q.push_back('{16'hBEEF, lm + LAT});
    exp_data = 16'hBEEF;
    settle_checks("beef");

    // Line raised too soon after a frame and held high: no frame, no error.
    drive(1'b0, 5);
    drive(1'b1, 40);
    settle_checks("hunt_high");

    // Accepted start bit, then the line never moves again: timeout error.
    expect_err();
    drive(1'b0, 24);
    drive(1'b1, 30);
    settle_checks("data_stuck");
    check("busy_after_err", {31'd0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
